// File: rtl/alu_pkg.sv
// Shared ALU opcode constants and the signed-overflow helper used by the
// add/subtract datapath.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow: like-signed operands producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_sign, input logic b_sign, input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One registered CW-bit slice of the carry chain: sums its operand chunks
// plus the incoming carry and registers sum, carry-out and beat valid.
module addsub_slice
  import alu_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          en_i,
  input  logic          valid_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          cin_i,
  output logic [CW-1:0] sum_o,
  output logic          cout_o,
  output logic          valid_o
);

  logic [CW:0]   total_d;
  logic [CW-1:0] sum_q;
  logic          cout_q;
  logic          valid_q;

  assign total_d = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, cin_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (en_i) begin
      sum_q   <= total_d[CW-1:0];
      cout_q  <= total_d[CW];
      valid_q <= valid_i;
    end
  end

  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract unit: STAGES registered carry-chain slices
// with operand skew, result deskew, valid/ready handshake and optional saturation.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iC,
  input  logic             iSub,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oData,
  output logic             oData_C,
  output logic             oOverflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic             en;
  // stg_*: what stage k consumes; a_w/b_w/sub_w: the same beat's operands aligned with slice k output
  logic [WIDTH-1:0] stg_a   [STAGES];
  logic [WIDTH-1:0] stg_b   [STAGES];
  logic             stg_sub [STAGES];
  logic             stg_v   [STAGES];
  logic             stg_c   [STAGES];
  logic [WIDTH-1:0] a_w     [STAGES];
  logic [WIDTH-1:0] b_w     [STAGES];
  logic             sub_w   [STAGES];
  logic [CW-1:0]    sum_w   [STAGES];
  logic             cout_w  [STAGES];
  logic             valid_w [STAGES];
  logic [WIDTH-1:0] lo_w    [STAGES];
  logic [WIDTH-1:0] done_w  [STAGES];
  logic [WIDTH-1:0] raw;

  assign en     = !oValid || iReady;
  assign oReady = en;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic             sub_q;

    if (gi == 0) begin : g_head
      // Subtract is A + ~B + ~borrow_in; the inversion happens once, at entry.
      assign stg_a[gi]   = iData_a;
      assign stg_b[gi]   = (iSub == OP_SUB) ? ~iData_b : iData_b;
      assign stg_sub[gi] = iSub;
      assign stg_v[gi]   = iValid;
      assign stg_c[gi]   = (iSub == OP_SUB) ? ~iC : iC;
      assign lo_w[gi]    = '0;
    end else begin : g_link
      logic [WIDTH-1:0] lo_q;

      assign stg_a[gi]   = a_w[gi-1];
      assign stg_b[gi]   = b_w[gi-1];
      assign stg_sub[gi] = sub_w[gi-1];
      assign stg_v[gi]   = valid_w[gi-1];
      assign stg_c[gi]   = cout_w[gi-1];

      // Completed lower chunks ride alongside the beat until the top chunk is done.
      always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
          lo_q <= '0;
        end else if (en) begin
          lo_q <= done_w[gi-1];
        end
      end
      assign lo_w[gi] = lo_q;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
        op_a_q <= '0;
        op_b_q <= '0;
        sub_q  <= OP_ADD;
      end else if (en) begin
        op_a_q <= stg_a[gi];
        op_b_q <= stg_b[gi];
        sub_q  <= stg_sub[gi];
      end
    end

    assign a_w[gi]   = op_a_q;
    assign b_w[gi]   = op_b_q;
    assign sub_w[gi] = sub_q;

    addsub_slice #(
      .CW(CW)
    ) u_slice (
      .clk_i  (iClk),
      .rst_ni (iRst_n),
      .en_i   (en),
      .valid_i(stg_v[gi]),
      .a_i    (stg_a[gi][gi*CW +: CW]),
      .b_i    (stg_b[gi][gi*CW +: CW]),
      .cin_i  (stg_c[gi]),
      .sum_o  (sum_w[gi]),
      .cout_o (cout_w[gi]),
      .valid_o(valid_w[gi])
    );

    assign done_w[gi] = lo_w[gi] | (WIDTH'(sum_w[gi]) << (gi * CW));
  end

  assign raw       = done_w[LAST];
  assign oValid    = valid_w[LAST];
  assign oData_C   = (sub_w[LAST] == OP_SUB) ? ~cout_w[LAST] : cout_w[LAST];
  assign oOverflow = signed_ovf(a_w[LAST][WIDTH-1], b_w[LAST][WIDTH-1], raw[WIDTH-1]);

  always_comb begin
    oData = raw;
    if (SATURATE) begin
      if (sub_w[LAST] == OP_ADD && cout_w[LAST]) begin
        oData = '1;
      end else if (sub_w[LAST] == OP_SUB && !cout_w[LAST]) begin
        oData = '0;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 8-bit/2-stage units (plain and
// saturating) sharing stimulus, plus a 32-bit/4-stage unit.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       v8, c8, s8, r8;
  logic [7:0] a8, b8;
  logic       or8, ov8, oc8, oo8;
  logic [7:0] od8;
  logic       or8s, ov8s, oc8s, oo8s;
  logic [7:0] od8s;
  logic        v32, c32, s32, r32;
  logic [31:0] a32, b32;
  logic        or32, ov32, oc32, oo32;
  logic [31:0] od32;

  int n_cmp = 0;
  int n_bad = 0;

  pipelined_addsub #(.WIDTH(8), .STAGES(2), .SATURATE(1'b0)) u_dut8 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v8), .oReady(or8), .iData_a(a8), .iData_b(b8),
    .iC(c8), .iSub(s8), .oValid(ov8), .iReady(r8), .oData(od8), .oData_C(oc8), .oOverflow(oo8)
  );

  pipelined_addsub #(.WIDTH(8), .STAGES(2), .SATURATE(1'b1)) u_dut8s (
    .iClk(clk), .iRst_n(rst_n), .iValid(v8), .oReady(or8s), .iData_a(a8), .iData_b(b8),
    .iC(c8), .iSub(s8), .oValid(ov8s), .iReady(r8), .oData(od8s), .oData_C(oc8s), .oOverflow(oo8s)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4), .SATURATE(1'b0)) u_dut32 (
    .iClk(clk), .iRst_n(rst_n), .iValid(v32), .oReady(or32), .iData_a(a32), .iData_b(b32),
    .iC(c32), .iSub(s32), .oValid(ov32), .iReady(r32), .oData(od32), .oData_C(oc32), .oOverflow(oo32)
  );

  // Vectors: a, b, carry/borrow-in, sub; expected raw data, C, V, saturated data
  logic [7:0] va   [11] = '{8'h00, 8'h01, 8'h20, 8'hFC, 8'hFC, 8'hFC, 8'h7F, 8'h80, 8'h05, 8'h80, 8'h09};
  logic [7:0] vb   [11] = '{8'h00, 8'h01, 8'h23, 8'h03, 8'h03, 8'h08, 8'h01, 8'h80, 8'h07, 8'h01, 8'h03};
  logic       vc   [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic       vs   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] ed   [11] = '{8'h00, 8'h03, 8'h44, 8'hFF, 8'h00, 8'h04, 8'h80, 8'h00, 8'hFE, 8'h7F, 8'h05};
  logic       ec   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       ev   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] esat [11] = '{8'h00, 8'h03, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h05};

  logic [7:0] bpa [4] = '{8'h11, 8'h40, 8'hF0, 8'h01};
  logic [7:0] bpb [4] = '{8'h22, 8'h05, 8'h20, 8'h02};
  logic       bpc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic [7:0] bpe [4] = '{8'h33, 8'h46, 8'h10, 8'h03};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    int j;
    int idx_in;
    int nout;

    rst_n = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; s8 = 1'b0; r8 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0; s32 = 1'b0; r32 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, ov8}, 32'd0);
    chk("rst_data", {24'd0, od8}, 32'd0);
    chk("rst_carry", {31'd0, oc8}, 32'd0);
    chk("rst_ovf", {31'd0, oo8}, 32'd0);
    chk("rst_valid32", {31'd0, ov32}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, or8}, 32'd1);
    chk("rdy_after_rst_sat", {31'd0, or8s}, 32'd1);
    chk("rdy_after_rst32", {31'd0, or32}, 32'd1);

    // Back-to-back add/overflow/subtract table; each result 2 cycles after its beat
    for (int t = 0; t < 14; t++) begin
      @(posedge clk); #1;
      if (t < 11) begin
        v8 = 1'b1; a8 = va[t]; b8 = vb[t]; c8 = vc[t]; s8 = vs[t];
      end else begin
        v8 = 1'b0;
      end
      @(negedge clk);
      if (t >= 2 && t < 13) begin
        j = t - 2;
        $display("beat %0d: a=%02h b=%02h c=%0d sub=%0d -> data=%02h C=%0d V=%0d sat=%02h",
                 j, va[j], vb[j], vc[j], vs[j], od8, oc8, oo8, od8s);
        chk($sformatf("vec%0d_valid", j), {31'd0, ov8}, 32'd1);
        chk($sformatf("vec%0d_data", j), {24'd0, od8}, {24'd0, ed[j]});
        chk($sformatf("vec%0d_carry", j), {31'd0, oc8}, {31'd0, ec[j]});
        chk($sformatf("vec%0d_ovf", j), {31'd0, oo8}, {31'd0, ev[j]});
        chk($sformatf("vec%0d_satdata", j), {24'd0, od8s}, {24'd0, esat[j]});
        chk($sformatf("vec%0d_satcarry", j), {31'd0, oc8s}, {31'd0, ec[j]});
      end else begin
        chk($sformatf("lat_idle_t%0d", t), {31'd0, ov8}, 32'd0);
      end
    end

    // Backpressure: 4 beats, iReady low for cycles 2..4 while a result is waiting
    idx_in = 0;
    nout   = 0;
    s8 = 1'b0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      r8 = !(t >= 2 && t <= 4);
      if (idx_in < 4) begin
        v8 = 1'b1; a8 = bpa[idx_in]; b8 = bpb[idx_in]; c8 = bpc[idx_in];
      end else begin
        v8 = 1'b0;
      end
      @(negedge clk);
      if (t >= 2 && t <= 4) begin
        chk($sformatf("stall_t%0d_ready", t), {31'd0, or8}, 32'd0);
        chk($sformatf("stall_t%0d_valid", t), {31'd0, ov8}, 32'd1);
        chk($sformatf("stall_t%0d_hold", t), {24'd0, od8}, {24'd0, bpe[0]});
      end
      if (ov8 && r8) begin
        $display("bp result %0d: data=%02h C=%0d", nout, od8, oc8);
        if (nout < 4) begin
          chk($sformatf("bp_res%0d", nout), {24'd0, od8}, {24'd0, bpe[nout]});
        end else begin
          chk("bp_extra_result", 32'(nout), 32'd3);
        end
        nout++;
      end
      if (v8 && or8) idx_in++;
    end
    chk("bp_count", 32'(nout), 32'd4);
    r8 = 1'b1;

    // Reset with two beats in flight
    @(posedge clk); #1 v8 = 1'b1; a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; s8 = 1'b0;
    @(posedge clk); #1 a8 = 8'hF0;
    @(posedge clk); #1 v8 = 1'b0;
    chk("pre_rst_valid", {31'd0, ov8}, 32'd1);
    chk("pre_rst_data", {24'd0, od8}, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-op reset: valid=%0d data=%02h C=%0d", ov8, od8, oc8);
    chk("midrst_valid", {31'd0, ov8}, 32'd0);
    chk("midrst_data", {24'd0, od8}, 32'd0);
    chk("midrst_carry", {31'd0, oc8}, 32'd0);
    chk("midrst_satdata", {24'd0, od8s}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk($sformatf("no_stale_t%0d", t), {31'd0, ov8}, 32'd0);
    end

    // 32-bit, 4-stage: latency 4, full-width carry ripple across slices
    @(posedge clk); #1 v32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; c32 = 1'b1;
    @(negedge clk); chk("w32_lat_t0", {31'd0, ov32}, 32'd0);
    @(posedge clk); #1 a32 = 32'h1234_5678; b32 = 32'h0FED_CBA9; c32 = 1'b0;
    @(negedge clk); chk("w32_lat_t1", {31'd0, ov32}, 32'd0);
    @(posedge clk); #1 v32 = 1'b0;
    @(negedge clk); chk("w32_lat_t2", {31'd0, ov32}, 32'd0);
    @(posedge clk);
    @(negedge clk); chk("w32_lat_t3", {31'd0, ov32}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    $display("w32 beat 0: data=%08h C=%0d V=%0d", od32, oc32, oo32);
    chk("w32_b0_valid", {31'd0, ov32}, 32'd1);
    chk("w32_b0_data", od32, 32'h0000_0000);
    chk("w32_b0_carry", {31'd0, oc32}, 32'd1);
    chk("w32_b0_ovf", {31'd0, oo32}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    $display("w32 beat 1: data=%08h C=%0d V=%0d", od32, oc32, oo32);
    chk("w32_b1_valid", {31'd0, ov32}, 32'd1);
    chk("w32_b1_data", od32, 32'h2222_2221);
    chk("w32_b1_carry", {31'd0, oc32}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("w32_drain", {31'd0, ov32}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
